// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StResp   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam logic [1:0] SizeWord = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;

endpackage

// File: rtl/lsu_decode.sv
// Combinational access decode: funct3/direction/address to size, signedness,
// misalignment and the naturally aligned address.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9
) (
  input  logic [2:0]            funct3_i,
  input  logic                  write_i,
  input  logic [DM_ADDRESS-1:0] addr_i,
  output logic [1:0]            size_o,
  output logic                  signed_o,
  output logic                  misalign_o,
  output logic [DM_ADDRESS-1:0] addr_o
);

  logic [1:0] size;

  always_comb begin
    // Unsigned encodings have no store counterpart, so stores fall back to word.
    case (funct3_i)
      F3Lb:    size = SizeByte;
      F3Lh:    size = SizeHalf;
      F3Lw:    size = SizeWord;
      F3Lbu:   size = write_i ? SizeWord : SizeByte;
      F3Lhu:   size = write_i ? SizeWord : SizeHalf;
      default: size = SizeWord;
    endcase

    misalign_o = ((size == SizeHalf) && addr_i[0]) ||
                 ((size == SizeWord) && (addr_i[1:0] != 2'b00));

    addr_o = addr_i;
    if (size == SizeHalf) begin
      addr_o[0] = 1'b0;
    end else if (size == SizeWord) begin
      addr_o[1:0] = 2'b00;
    end

    size_o   = size;
    signed_o = ~funct3_i[2];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one-cycle stores, fixed-latency loads with response.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LOAD_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [4:0]            req_rd,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic [4:0]            resp_rd,
  output logic                  resp_misalign,
  output logic                  dm_MemRead,
  output logic                  dm_MemWrite,
  output logic [DM_ADDRESS-1:0] dm_a,
  output logic [DATA_W-1:0]     dm_wd,
  output logic [1:0]            dm_LoadSize,
  output logic                  dm_LoadSigned,
  output logic [2:0]            dm_Funct3,
  input  logic [DATA_W-1:0]     dm_rd
);

  localparam int unsigned CntW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  lsu_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [4:0]            tag_q, tag_d;
  logic                  dm_mem_read_q, dm_mem_read_d;
  logic                  dm_mem_write_q, dm_mem_write_d;
  logic [DM_ADDRESS-1:0] dm_a_q, dm_a_d;
  logic [DATA_W-1:0]     dm_wd_q, dm_wd_d;
  logic [1:0]            dm_load_size_q, dm_load_size_d;
  logic                  dm_load_signed_q, dm_load_signed_d;
  logic [2:0]            dm_funct3_q, dm_funct3_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic [4:0]            resp_rd_q, resp_rd_d;

  logic [1:0]            dec_size;
  logic                  dec_signed;
  logic                  dec_misalign;
  logic [DM_ADDRESS-1:0] dec_addr;
  logic                  accept;
  logic                  issue;

  lsu_decode #(
    .DM_ADDRESS (DM_ADDRESS)
  ) u_decode (
    .funct3_i   (req_funct3),
    .write_i    (req_write),
    .addr_i     (req_addr),
    .size_o     (dec_size),
    .signed_o   (dec_signed),
    .misalign_o (dec_misalign),
    .addr_o     (dec_addr)
  );

  // A trap response sits in IDLE, so hold off one cycle to keep responses spaced.
  assign req_ready = (state_q == StIdle) && !flush && !resp_valid_q;
  assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_misalign_q, resp_misalign_d;
  assign resp_misalign = resp_misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = dec_misalign;
  assign resp_misalign   = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    tag_d            = tag_q;
    dm_mem_read_d    = 1'b0;
    dm_mem_write_d   = 1'b0;
    dm_a_d           = '0;
    dm_wd_d          = '0;
    dm_load_size_d   = '0;
    dm_load_signed_d = 1'b0;
    dm_funct3_d      = '0;
    resp_valid_d     = 1'b0;
    resp_data_d      = resp_data_q;
    resp_rd_d        = resp_rd_q;
    issue            = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    resp_misalign_d  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (dec_misalign) begin
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b1;
            resp_data_d     = '0;
            resp_rd_d       = req_rd;
          end else begin
            issue = 1'b1;
          end
`else
          issue = 1'b1;
`endif
        end
      end
      StRdWait: begin
        if (cnt_q == '0) begin
          resp_data_d  = dm_rd;
          resp_rd_d    = tag_q;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue) begin
      dm_a_d      = dec_addr;
      dm_funct3_d = req_funct3;
      if (req_write) begin
        dm_mem_write_d = 1'b1;
        dm_wd_d        = req_wdata;
      end else begin
        dm_mem_read_d    = 1'b1;
        dm_load_size_d   = dec_size;
        dm_load_signed_d = dec_signed;
        tag_d            = req_rd;
        cnt_d            = CntW'(LOAD_LAT);
        state_d          = StRdWait;
      end
    end

    // Kill any in-flight load; the response registers keep their old contents.
    if (flush) begin
      state_d      = StIdle;
      cnt_d        = '0;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_rd_d    = resp_rd_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      tag_q            <= '0;
      dm_mem_read_q    <= 1'b0;
      dm_mem_write_q   <= 1'b0;
      dm_a_q           <= '0;
      dm_wd_q          <= '0;
      dm_load_size_q   <= '0;
      dm_load_signed_q <= 1'b0;
      dm_funct3_q      <= '0;
      resp_valid_q     <= 1'b0;
      resp_data_q      <= '0;
      resp_rd_q        <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_misalign_q  <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      tag_q            <= tag_d;
      dm_mem_read_q    <= dm_mem_read_d;
      dm_mem_write_q   <= dm_mem_write_d;
      dm_a_q           <= dm_a_d;
      dm_wd_q          <= dm_wd_d;
      dm_load_size_q   <= dm_load_size_d;
      dm_load_signed_q <= dm_load_signed_d;
      dm_funct3_q      <= dm_funct3_d;
      resp_valid_q     <= resp_valid_d;
      resp_data_q      <= resp_data_d;
      resp_rd_q        <= resp_rd_d;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_misalign_q  <= resp_misalign_d;
`endif
    end
  end

  assign dm_MemRead    = dm_mem_read_q;
  assign dm_MemWrite   = dm_mem_write_q;
  assign dm_a          = dm_a_q;
  assign dm_wd         = dm_wd_q;
  assign dm_LoadSize   = dm_load_size_q;
  assign dm_LoadSigned = dm_load_signed_q;
  assign dm_Funct3     = dm_funct3_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_rd       = resp_rd_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter DM_ADDRESS, default 9, data memory byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have parameter LOAD_LAT, default 2, cycles from the dm_MemRead cycle to valid dm_rd.
REQ-004 The block SHALL have the port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the ports req_valid (input, 1), req_ready (output, 1), req_write (input, 1; 1=store) and req_funct3 (input, 3): request handshake and access type.
REQ-007 The block SHALL have the ports req_addr (input, DM_ADDRESS), req_wdata (input, DATA_W) and req_rd (input, 5; destination register tag).
REQ-008 The block SHALL have the input port flush, 1 bit: kills the pending request and any in-flight load.
REQ-009 The block SHALL have the output ports resp_valid (1), resp_data (DATA_W), resp_rd (5) and resp_misalign (1).
REQ-010 The block SHALL have the output ports dm_MemRead (1), dm_MemWrite (1), dm_a (DM_ADDRESS), dm_wd (DATA_W), dm_LoadSize (2), dm_LoadSigned (1) and dm_Funct3 (3), all registered, plus the input port dm_rd (DATA_W).

Function
REQ-011 Decode SHALL map funct3 000/001/010/100/101 to LB/LH/LW/LBU/LHU; stores SHALL use 000/001/010; funct3 011/110/111 SHALL be treated as word.
REQ-012 dm_LoadSize SHALL be 00 for word, 01 for half and 10 for byte; dm_LoadSigned SHALL equal ~funct3[2].
REQ-013 The FSM SHALL have the states IDLE, RD_WAIT and RESP; req_ready SHALL be 1 only in IDLE while flush=0.
REQ-014 A store accepted in cycle N SHALL drive dm_MemWrite=1, dm_a, dm_wd and dm_Funct3 in cycle N+1 for exactly one cycle, produce no resp_valid, and leave the FSM in IDLE, so back-to-back stores proceed at one per cycle.
REQ-015 A load accepted in cycle N SHALL drive dm_MemRead=1 with dm_a, dm_LoadSize and dm_LoadSigned in cycle N+1 for one cycle, and the FSM SHALL enter RD_WAIT.
REQ-016 RD_WAIT SHALL last LOAD_LAT+1 cycles via a down-counter; dm_rd SHALL be captured on the last edge, and the FSM SHALL then enter RESP.
REQ-017 RESP SHALL assert resp_valid for exactly one cycle with resp_data equal to the captured dm_rd and resp_rd equal to the request tag, then return to IDLE; with default parameters resp_valid SHALL assert in cycle N+4.
REQ-018 flush SHALL take priority over req_valid in the same cycle: the request is not accepted, a pending dm_MemRead/dm_MemWrite pulse is dropped, the FSM returns to IDLE next cycle, and no resp_valid is produced for the killed load.
REQ-019 dm_MemRead and dm_MemWrite SHALL never be asserted in the same cycle.
REQ-020 resp_valid SHALL never be asserted in two consecutive cycles.

Reset
REQ-021 An asynchronous reset SHALL force IDLE and set the counter, every dm_* output, resp_valid, resp_data, resp_rd and resp_misalign to 0, including reset asserted mid-RD_WAIT.
REQ-022 After reset deassertion, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-023 The macro LSU_MISALIGN_TRAP_EN SHALL select misaligned-access handling; an access is misaligned when it is a half with addr[0]=1 or a word with addr[1:0]!=0.
REQ-024 With LSU_MISALIGN_TRAP_EN defined, a misaligned load or store SHALL be accepted, issue no dm access, and return resp_valid=1, resp_misalign=1 and resp_data=0 in cycle N+1 with the FSM staying in IDLE.
REQ-025 Without LSU_MISALIGN_TRAP_EN, the offending low address bits SHALL be cleared and the access proceeds normally, and resp_misalign SHALL be tied to 0.

Structure
REQ-026 The package lsu_pkg SHALL hold the FSM state enum, the funct3 localparams and the LoadSize encodings.
REQ-027 The sub-module lsu_decode SHALL be combinational and map funct3/req_write/addr to size, signed and misaligned.

Verification
REQ-028 LW at 0x010 accepted in cycle 0 with dm_rd=0xDEADBEEF -> dm_MemRead=1 in cycle 1 only; resp_valid in cycle 4 with resp_data=0xDEADBEEF and resp_rd=tag.
REQ-029 Three back-to-back SB/SH/SW at 0x004 -> dm_MemWrite=1 in cycles 1-3 with dm_Funct3 000/001/010; req_ready stays 1; no resp_valid.
REQ-030 LBU at 0x003 -> dm_LoadSize=10 and dm_LoadSigned=0; LH at 0x002 -> dm_LoadSize=01 and dm_LoadSigned=1.
REQ-031 flush in cycle 2 of a load -> no resp_valid, req_ready=1 in cycle 3; a new LW accepted in cycle 3 returns its own data in cycle 7.
REQ-032 LW at 0x006 with LSU_MISALIGN_TRAP_EN -> resp_valid and resp_misalign in cycle 1 with no dm_MemRead; without the macro -> dm_a=0x004.
REQ-033 reset asserted in RD_WAIT -> all outputs 0 at once and no resp_valid after release.
